// File: rtl/instr_fetch_decode.sv
// rtl/instr_fetch_decode.sv - multicycle instruction fetch/decode stage for the 16-bit datapath
module instr_fetch_decode #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_en,
  input  logic [15:0]       mem_rdata,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_target,
  input  logic              ready,
  output logic              valid,
  output logic [15:0]       ir,
  output logic [ADDR_W-1:0] pc,
  output logic [3:0]        op,
  output logic [3:0]        opext,
  output logic [3:0]        rdest,
  output logic [3:0]        rsrc,
  output logic [7:0]        imm,
  output logic              sign,
  output logic              is_imm
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_WAIT   = 2'd1,
    S_DECODE = 2'd2
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_en;
  logic [15:0]       r_ir;
  logic              r_valid;

  logic [ADDR_W-1:0] w_pc_inc;
  logic              w_is_imm;
  logic              w_sign;

  assign w_pc_inc = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};

  // Fetch sequencer: mem_en is high only while in FETCH; the read returns
  // during WAIT and is latched into ir; DECODE holds until ready or redirect.
  // After reset FETCH spends one idle cycle raising mem_en, so the first
  // instruction becomes valid in the third cycle after release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_FETCH;
      r_pc       <= RESET_PC;
      r_mem_addr <= RESET_PC;
      r_mem_en   <= 1'b0;
      r_ir       <= 16'h0000;
      r_valid    <= 1'b0;
    end else if (pc_load) begin
      // Redirect wins over everything: any in-flight read is dropped because
      // ir is only written from WAIT, and the new fetch starts immediately.
      r_state    <= S_FETCH;
      r_pc       <= pc_target;
      r_mem_addr <= pc_target;
      r_mem_en   <= 1'b1;
      r_valid    <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (!r_mem_en) begin
            r_mem_en   <= 1'b1;
            r_mem_addr <= r_pc;
          end else begin
            r_mem_en <= 1'b0;
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_ir    <= mem_rdata;
          r_valid <= 1'b1;
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          if (ready) begin
            r_valid    <= 1'b0;
            r_pc       <= w_pc_inc;
            r_mem_addr <= w_pc_inc;
            r_mem_en   <= 1'b1;
            r_state    <= S_FETCH;
          end
        end
        default: begin
          r_mem_en <= 1'b0;
          r_valid  <= 1'b0;
          r_state  <= S_FETCH;
        end
      endcase
    end
  end

  // Opcode decode: which instructions take the immediate and how it extends.
  always_comb begin
    w_is_imm = 1'b0;
    w_sign   = 1'b0;
    case (r_ir[15:12])
      4'b0001, 4'b0010, 4'b0011, 4'b1101, 4'b1111: begin
        w_is_imm = 1'b1;
        w_sign   = 1'b0;
      end
      4'b0101, 4'b1001, 4'b1011, 4'b1100: begin
        w_is_imm = 1'b1;
        w_sign   = 1'b1;
      end
      4'b1000: begin
        // Shift class: immediate form has opext[0] clear.
        w_is_imm = ~r_ir[4];
        w_sign   = 1'b1;
      end
      default: begin
        w_is_imm = 1'b0;
        w_sign   = 1'b0;
      end
    endcase
  end

  assign mem_addr = r_mem_addr;
  assign mem_en   = r_mem_en;
  assign valid    = r_valid;
  assign ir       = r_ir;
  assign pc       = r_pc;
  assign op       = r_ir[15:12];
  assign rdest    = r_ir[11:8];
  assign opext    = r_ir[7:4];
  assign rsrc     = r_ir[3:0];
  assign imm      = r_ir[7:0];
  assign sign     = w_sign;
  assign is_imm   = w_is_imm;

endmodule

// File: doc/instr_fetch_decode.md
Name: instr_fetch_decode

Overview:
- Multicycle instruction fetch/decode stage for the 16-bit CR16-style datapath.
- Fetches one instruction word per instruction from block memory and holds it in an instruction register (IR).
- Splits the IR into register indices, opcode fields and an 8-bit immediate.
- Drives the sign-select for the downstream 8-to-16 sign extender. It is the stage directly upstream of the extender and the ALU/register-file datapath.

Parameters:
ADDR_W, 16, instruction memory address / PC width in bits
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  system clock; all state updates on its rising edge
reset  in  1  asynchronous, active-high reset
mem_addr  out  ADDR_W  instruction memory read address
mem_en  out  1  memory read enable
mem_rdata  in  16  memory read data, valid exactly one cycle after mem_en
pc_load  in  1  branch/jump redirect request from execute
pc_target  in  ADDR_W  redirect target address
ready  in  1  datapath accepts the current decoded instruction
valid  out  1  decoded fields are stable and meaningful
ir  out  16  latched instruction word
pc  out  ADDR_W  address of the instruction in ir
op  out  4  ir[15:12]
opext  out  4  ir[7:4]
rdest  out  4  ir[11:8]
rsrc  out  4  ir[3:0]
imm  out  8  ir[7:0], feeds extender imm input
sign  out  1  1 = sign-extend imm, 0 = zero-extend; feeds extender sign input
is_imm  out  1  instruction uses imm instead of rsrc

Behaviour:
- Reset (async, any state): state=FETCH, pc=RESET_PC, ir=16'h0000, valid=0, mem_en=0, mem_addr=RESET_PC. All decoded outputs then read 0.
- FSM states FETCH -> WAIT -> DECODE -> FETCH.
- FETCH: mem_en=1, mem_addr=pc for one cycle; next state WAIT.
- WAIT: mem_en=0; mem_rdata is captured into ir at the end of this cycle; next state DECODE.
- DECODE: valid=1. Fields are combinational from ir and stay stable while valid=1.
  - On ready=1: valid drops next cycle, pc <= pc+1 (wraps from all-ones to 0), next state FETCH.
  - On ready=0: remain in DECODE, ir/pc held.
- Fetch latency: 3 cycles from FETCH entry to valid; minimum 3 cycles per instruction.
- Decode table (op -> is_imm, sign):
  - 0000 register class -> 0, 0
  - 0001 ANDI, 0010 ORI, 0011 XORI, 1101 MOVI, 1111 LUI -> 1, 0
  - 0101 ADDI, 1001 SUBI, 1011 CMPI -> 1, 1
  - 1100 Bcond (imm = displacement) -> 1, 1
  - 1000 shift class: is_imm = ~opext[0] (LSHI when opext[3:1]==000), sign=1
  - 0100 load/store/jcond -> 0, 0
  - all other ops -> 0, 0
- pc_load is honoured in any state. On its cycle: pc <= pc_target, valid <= 0, next state FETCH.
  - A read in flight (WAIT) is discarded: ir is not updated.
  - Redirect takes priority over ready in DECODE: no increment, instruction consumed.
- pc_load and reset together: reset wins.
- Reset asserted mid-WAIT: memory data arriving after reset release is ignored; first fetch after release is from RESET_PC.
- mem_en is never high outside FETCH. No new fetch is issued while valid=1 and ready=0.

Test Plan:
- Reset then release, memory[0]=16'h5AFF (ADDI R10,#-1) -> mem_en pulses in cycle 1. valid=1 in cycle 3 with ir=5AFF, rdest=A, imm=FF, is_imm=1, sign=1; extender output 16'hFFFF.
- memory[1]=16'h13FF (ANDI R3,#FF), ready held 1 -> second valid with pc=1, sign=0, is_imm=1; extender output 16'h00FF.
- ready held 0 for 5 cycles in DECODE -> valid stays 1, ir/pc unchanged, mem_en stays 0. ready=1 -> pc=2, next fetch addr 2.
- pc_load=1, pc_target=16'h0040 during WAIT -> ir keeps old value, next mem_addr=0040, valid first rises with pc=0040.
- Reset asserted in DECODE with pc=7 -> valid=0 and ir=0 immediately (async). After release, fetch from RESET_PC.
- pc=16'hFFFF, ready=1 -> pc wraps to 0000. Register-class word 16'h0152 gives is_imm=0, sign=0, rsrc=2, opext=5.
